mul_seq_unit: RTL

//  Iterative shift-add multiplier executing the M-extension ops decoded by the control unit
//  (aluop MUL=4'b0101, MULH=4'b0110, MULHU=4'b0111). Sits beside the combinational ALU in the

---
 rtl/core_pkg.sv | 21 ++
 rtl/mul_step.sv | 29 ++
 rtl/mul_seq_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: ALU opcodes seen by the control unit, ALU and multiplier,
// plus the multiplier FSM state type.
package core_pkg;

  typedef logic [3:0] aluop_t;

  localparam aluop_t ALUOP_MUL   = 4'b0101;
  localparam aluop_t ALUOP_MULH  = 4'b0110;
  localparam aluop_t ALUOP_MULHU = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  function automatic logic is_mul_op(input aluop_t op);
    return (op == ALUOP_MUL) || (op == ALUOP_MULH) || (op == ALUOP_MULHU);
  endfunction

endpackage

// File: rtl/mul_step.sv
// One iteration of the shift-add multiplier: adds BPC partial products of the
// multiplicand, each placed at its bit position within the double-width accumulator.
module mul_step #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1,
  parameter int CW    = 6
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   ma,
  input  logic [BPC-1:0]     mb_bits,
  input  logic [CW-1:0]      cnt,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [2*WIDTH-1:0] ma_ext;

  assign ma_ext = {{WIDTH{1'b0}}, ma};

  // Bit i of this step's multiplier slice has weight 2^(cnt*BPC + i).
  always_comb begin
    acc_next = acc;
    for (int i = 0; i < BPC; i++) begin
      if (mb_bits[i]) begin
        acc_next = acc_next + (ma_ext << (int'(cnt) * BPC + i));
      end
    end
  end

endmodule

// File: rtl/mul_seq_unit.sv
// Iterative multiplier for MUL/MULH/MULHU. Stalls the core from acceptance until the
// cycle before the one-cycle done pulse that carries the selected product half.
module mul_seq_unit
  import core_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int STEPS = WIDTH / BPC;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

  mul_state_e         state_q, state_d;
  aluop_t             op_q, op_d;
  logic [WIDTH-1:0]   ma_q, ma_d;
  logic [WIDTH-1:0]   mb_q, mb_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               done_q, done_d;

  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic               accept;

  mul_step #(
    .WIDTH (WIDTH),
    .BPC   (BPC),
    .CW    (CW)
  ) u_step (
    .acc      (acc_q),
    .ma       (ma_q),
    .mb_bits  (mb_q[BPC-1:0]),
    .cnt      (cnt_q),
    .acc_next (acc_step)
  );

  // Magnitude of the most negative value wraps to itself, which is correct unsigned.
  assign a_abs  = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_abs  = b[WIDTH-1] ? (~b + 1'b1) : b;
  assign accept = (state_q == IDLE) && valid_in && is_mul_op(aluop);
  assign prod   = neg_q ? (~acc_step + 1'b1) : acc_step;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = aluop;
          acc_d = '0;
          cnt_d = '0;
          if (aluop == ALUOP_MULH) begin
            ma_d  = a_abs;
            mb_d  = b_abs;
            neg_d = a[WIDTH-1] ^ b[WIDTH-1];
          end else begin
            ma_d  = a;
            mb_d  = b;
            neg_d = 1'b0;
          end
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_step;
        mb_d  = mb_q >> BPC;
        cnt_d = cnt_q + CW'(1);
        // Result is registered on the final step so it is stable throughout DONE.
        if (cnt_q == LAST_CNT) begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = (op_q == ALUOP_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign stall  = accept || (state_q == RUN);
  assign done   = done_q;
  assign result = result_q;

endmodule
